traffic_seq: RTL
================

TRAFFIC_SEQ -- requirements
Module: traffic_seq

Interface
REQ-001 The module SHALL provide a single clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port: enable_i  input  1  phase-advance strobe from the enable generator, combinational from counter_o.
REQ-005 Port: ped_btn_i  input  1  pedestrian button, level or pulse, already synchronised.
REQ-006 Port: main_traffic_i  input  3  raw main-road traffic level.
REQ-007 Port: side_traffic_i  input  3  raw side-road traffic level.
REQ-008 Port: counter_o  output  6  cycle counter fed to the enable generator.
REQ-009 Port: ped_o  output  1  latched pedestrian request fed to the enable generator PED input.
REQ-010 Port: main_traffic_o / side_traffic_o  output  3 each  per-cycle traffic snapshots fed to the enable generator.
REQ-011 Port: main_light_o / side_light_o  output  3 each  one-hot lamp drive, bit2 red, bit1 yellow, bit0 green.
REQ-012 Port: walk_o  output  1  pedestrian walk lamp.
REQ-013 Port: state_o  output  3  current phase encoding, for debug.

Function
REQ-014 The FSM SHALL have seven states, encoded 0-6: MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, ALL_R2, PED_WALK.
REQ-015 The FSM SHALL change state only on a rising edge where enable_i=1, following MAIN_G->MAIN_Y->ALL_R1->SIDE_G->SIDE_Y->ALL_R2.
REQ-016 From ALL_R2, on enable_i: next state SHALL be PED_WALK if ped_o=1, otherwise MAIN_G.
REQ-017 From PED_WALK, on enable_i: next state SHALL be MAIN_G.
REQ-018 Counter default behaviour: counter_o SHALL increment by 1 every clock.
REQ-019 Wrap event (enable_i in ALL_R2 with ped_o=0, or enable_i in PED_WALK): counter_o SHALL load 0 on that edge.
REQ-020 Watchdog: counter_o=63 with no wrap event SHALL load counter 0 and state MAIN_G on the next edge; ped_o is unchanged.
REQ-021 Snapshot capture: on every wrap or watchdog edge, main_traffic_o and side_traffic_o SHALL capture main_traffic_i and side_traffic_i.
REQ-022 Snapshot hold: between capture edges main_traffic_o and side_traffic_o SHALL hold stable, so comparator results are fixed for a whole cycle.
REQ-023 ped_o SHALL set on the edge after ped_btn_i=1 in any state other than PED_WALK.
REQ-024 Button presses while in PED_WALK SHALL be ignored.
REQ-025 ped_o SHALL clear on the edge leaving PED_WALK; if the button is pressed on that same cycle, the clear wins.
REQ-026 Lights SHALL be registered decodes of the next state, so lamps change on the same edge as state_o.
REQ-027 Lamp values per state: MAIN_G main=001 side=100; MAIN_Y main=010 side=100; ALL_R1/ALL_R2 both 100; SIDE_G main=100 side=001; SIDE_Y main=100 side=010; PED_WALK both 100, walk_o=1.
REQ-028 walk_o SHALL be 0 in every state other than PED_WALK.
REQ-029 enable_i asserted on consecutive cycles SHALL advance one state per cycle; there is no filtering.

Reset
REQ-030 On rst_n=0 at a clk edge the outputs SHALL take: state MAIN_G, counter_o=0, ped_o=0, snapshots=0, main_light_o=001, side_light_o=100, walk_o=0.
REQ-031 Reset SHALL override all other events, including a simultaneous enable_i or ped_btn_i, mid-cycle or mid-PED_WALK.

Verification
REQ-032 Nominal cycle, no ped: traffic main=2 side=2, enable pulses at counter 11,13,15,25,27,29 -> states step MAIN_G..ALL_R2->MAIN_G, counter_o=0 after count 29, lamps per REQ-027.
REQ-033 Ped request: button pulse at counter 5, enables adding count 39 -> ped_o=1 from count 6, PED_WALK from count 30 with walk_o=1, MAIN_G and ped_o=0 after 39, counter_o=0.
REQ-034 Button during PED_WALK and at exit edge -> ped_o stays 0 after exit.
REQ-035 Snapshot: change main_traffic_i 2->5 at counter 12 -> main_traffic_o stays 2 until the wrap edge, then 5.
REQ-036 Watchdog: enable_i held 0 -> counter_o 63 then 0, state MAIN_G.
REQ-037 Reset mid-operation: rst_n=0 in SIDE_G at counter 20 with enable_i=1 -> all reset values next edge.

Source files
------------

// File: rtl/traffic_seq.sv
// traffic_seq: seven-phase junction sequencer with pedestrian request, cycle counter, watchdog and traffic snapshots
module traffic_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       ped_btn_i,
  input  logic [2:0] main_traffic_i,
  input  logic [2:0] side_traffic_i,
  output logic [5:0] counter_o,
  output logic       ped_o,
  output logic [2:0] main_traffic_o,
  output logic [2:0] side_traffic_o,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       walk_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, ALL_R2, PED_WALK} state_t;
  state_t state, nxt;
  logic wrap, wd, ped_nxt;
  logic [2:0] ml_nxt, sl_nxt;
  assign state_o = state;
  // next phase, wrap/watchdog detection, pedestrian latch and lamp decode of the next phase
  always_comb begin
    wrap = enable_i && ((state == ALL_R2 && !ped_o) || state == PED_WALK);
    wd = counter_o == 6'd63 && !wrap;
    nxt = state;
    if (wd) nxt = MAIN_G;
    else if (enable_i)
      nxt = state == ALL_R2 ? (ped_o ? PED_WALK : MAIN_G) :
            state == PED_WALK ? MAIN_G : state_t'(state + 3'd1);
    ped_nxt = wd ? ped_o : state == PED_WALK ? ped_o && !enable_i : ped_o || ped_btn_i;
    ml_nxt = nxt == MAIN_G ? 3'b001 : nxt == MAIN_Y ? 3'b010 : 3'b100;
    sl_nxt = nxt == SIDE_G ? 3'b001 : nxt == SIDE_Y ? 3'b010 : 3'b100;
  end
  // state, counter, snapshots and registered lamp outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MAIN_G;
      counter_o <= '0;
      ped_o <= 1'b0;
      main_traffic_o <= '0;
      side_traffic_o <= '0;
      main_light_o <= 3'b001;
      side_light_o <= 3'b100;
      walk_o <= 1'b0;
    end else begin
      state <= nxt;
      counter_o <= (wrap || wd) ? 6'd0 : counter_o + 6'd1;
      ped_o <= ped_nxt;
      if (wrap || wd) begin
        main_traffic_o <= main_traffic_i;
        side_traffic_o <= side_traffic_i;
      end
      main_light_o <= ml_nxt;
      side_light_o <= sl_nxt;
      walk_o <= nxt == PED_WALK;
    end
  end
endmodule
